// File: rtl/tiro_banco.sv
// Multi-slot projectile engine: fires into the lowest free slot and sweeps all slots one per cycle.
// Optional macro TIRO_WRAP_EN: shots wrap to the opposite border instead of being removed.
module tiro_banco #(
  parameter int N_TIROS   = 16,
  parameter int COORD_W   = 4,
  parameter int COORD_MIN = 0,
  parameter int COORD_MAX = 14
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             disparo,
  input  logic                             atualiza,
  input  logic [COORD_W-1:0]               nave_x,
  input  logic [COORD_W-1:0]               nave_y,
  input  logic [1:0]                       nave_opcode,
  input  logic [COORD_W-1:0]               aste_x,
  input  logic [COORD_W-1:0]               aste_y,
  input  logic                             aste_valido,
  input  logic [$clog2(N_TIROS)-1:0]       db_idx,
  output logic                             ocupado,
  output logic                             disparo_aceito,
  output logic                             disparo_recusado,
  output logic                             colisao,
  output logic [$clog2(N_TIROS)-1:0]       colisao_idx,
  output logic                             borda,
  output logic                             varredura_fim,
  output logic [$clog2(N_TIROS+1)-1:0]     tiros_ativos,
  output logic [COORD_W-1:0]               db_x,
  output logic [COORD_W-1:0]               db_y,
  output logic [1:0]                       db_opcode,
  output logic                             db_loaded
);

  localparam int IDX_W = $clog2(N_TIROS);
  localparam int CNT_W = $clog2(N_TIROS + 1);
  localparam logic [COORD_W-1:0] CMIN = COORD_W'(COORD_MIN);
  localparam logic [COORD_W-1:0] CMAX = COORD_W'(COORD_MAX);
  localparam logic [COORD_W-1:0] UM   = COORD_W'(1);
`ifdef TIRO_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [1:0] {OCIOSO, VARRE, FIM} estado_t;

  estado_t              estado;
  logic [COORD_W-1:0]   pos_x [N_TIROS];
  logic [COORD_W-1:0]   pos_y [N_TIROS];
  logic [1:0]           opc   [N_TIROS];
  logic [N_TIROS-1:0]   loaded;
  logic [IDX_W-1:0]     idx;

  logic                 livre_ok;
  logic [IDX_W-1:0]     livre_idx;
  logic [COORD_W-1:0]   cx, cy, nx, ny;
  logic                 na_borda, acerto;

  // Scan from the top down so the last assignment wins for the lowest free slot.
  always_comb begin
    livre_ok  = 1'b0;
    livre_idx = '0;
    for (int unsigned k = N_TIROS; k > 0; k--) begin
      if (!loaded[k-1]) begin
        livre_ok  = 1'b1;
        livre_idx = IDX_W'(k - 1);
      end
    end
  end

  // Border test precedes the step; the border value is the wrap target.
  always_comb begin
    cx       = pos_x[idx];
    cy       = pos_y[idx];
    nx       = cx;
    ny       = cy;
    na_borda = 1'b0;
    case (opc[idx])
      2'b00: if (cy == CMIN) begin na_borda = 1'b1; ny = CMAX; end else ny = cy - UM;
      2'b01: if (cy == CMAX) begin na_borda = 1'b1; ny = CMIN; end else ny = cy + UM;
      2'b10: if (cx == CMIN) begin na_borda = 1'b1; nx = CMAX; end else nx = cx - UM;
      default: if (cx == CMAX) begin na_borda = 1'b1; nx = CMIN; end else nx = cx + UM;
    endcase
    acerto = aste_valido && (nx == aste_x) && (ny == aste_y);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado           <= OCIOSO;
      loaded           <= '0;
      idx              <= '0;
      tiros_ativos     <= '0;
      colisao_idx      <= '0;
      ocupado          <= 1'b0;
      disparo_aceito   <= 1'b0;
      disparo_recusado <= 1'b0;
      colisao          <= 1'b0;
      borda            <= 1'b0;
      varredura_fim    <= 1'b0;
      for (int unsigned k = 0; k < N_TIROS; k++) begin
        pos_x[k] <= '0;
        pos_y[k] <= '0;
        opc[k]   <= '0;
      end
    end else begin
      disparo_aceito   <= 1'b0;
      disparo_recusado <= 1'b0;
      colisao          <= 1'b0;
      borda            <= 1'b0;
      varredura_fim    <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (disparo) begin
            if (livre_ok) begin
              pos_x[livre_idx]  <= nave_x;
              pos_y[livre_idx]  <= nave_y;
              opc[livre_idx]    <= nave_opcode;
              loaded[livre_idx] <= 1'b1;
              tiros_ativos      <= tiros_ativos + CNT_W'(1);
              disparo_aceito    <= 1'b1;
            end else begin
              disparo_recusado <= 1'b1;
            end
          end
          if (atualiza) begin
            idx     <= '0;
            ocupado <= 1'b1;
            estado  <= VARRE;
          end
        end
        VARRE: begin
          if (disparo) disparo_recusado <= 1'b1;
          if (loaded[idx]) begin
            if (na_borda && !WRAP) begin
              loaded[idx]  <= 1'b0;
              borda        <= 1'b1;
              tiros_ativos <= tiros_ativos - CNT_W'(1);
            end else begin
              pos_x[idx] <= nx;
              pos_y[idx] <= ny;
              if (acerto) begin
                loaded[idx]  <= 1'b0;
                colisao      <= 1'b1;
                colisao_idx  <= idx;
                tiros_ativos <= tiros_ativos - CNT_W'(1);
              end
            end
          end
          if (idx == IDX_W'(N_TIROS - 1)) estado <= FIM;
          else                            idx    <= idx + IDX_W'(1);
        end
        FIM: begin
          if (disparo) disparo_recusado <= 1'b1;
          varredura_fim <= 1'b1;
          ocupado       <= 1'b0;
          estado        <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign db_x      = pos_x[db_idx];
  assign db_y      = pos_y[db_idx];
  assign db_opcode = opc[db_idx];
  assign db_loaded = loaded[db_idx];

endmodule

// File: tb/tb_tiro_banco.sv
// Self-checking bench for tiro_banco: directed scenarios plus randomized fire/sweep traffic vs a slot-level model.
module tb_tiro_banco;
  localparam int N = 16, W = 4, CMIN = 0, CMAX = 14, IW = 4, CW = 5;

  logic clock = 1'b0, reset = 1'b0;
  logic disparo = 1'b0, atualiza = 1'b0, aste_valido = 1'b0;
  logic [W-1:0] nave_x = '0, nave_y = '0, aste_x = '0, aste_y = '0;
  logic [1:0] nave_opcode = '0;
  logic [IW-1:0] db_idx = '0;
  logic ocupado, disparo_aceito, disparo_recusado, colisao, borda, varredura_fim, db_loaded;
  logic [IW-1:0] colisao_idx;
  logic [CW-1:0] tiros_ativos;
  logic [W-1:0] db_x, db_y;
  logic [1:0] db_opcode;

  tiro_banco #(.N_TIROS(N), .COORD_W(W), .COORD_MIN(CMIN), .COORD_MAX(CMAX)) dut (
    .clock(clock), .reset(reset), .disparo(disparo), .atualiza(atualiza),
    .nave_x(nave_x), .nave_y(nave_y), .nave_opcode(nave_opcode),
    .aste_x(aste_x), .aste_y(aste_y), .aste_valido(aste_valido), .db_idx(db_idx),
    .ocupado(ocupado), .disparo_aceito(disparo_aceito), .disparo_recusado(disparo_recusado),
    .colisao(colisao), .colisao_idx(colisao_idx), .borda(borda), .varredura_fim(varredura_fim),
    .tiros_ativos(tiros_ativos), .db_x(db_x), .db_y(db_y), .db_opcode(db_opcode), .db_loaded(db_loaded)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  int mx[N], my[N], mo[N], ev[N];
  bit ml[N];
  int last_hit = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += ml[i];
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin mx[i] = 0; my[i] = 0; mo[i] = 0; ml[i] = 0; ev[i] = 0; end
    last_hit = 0;
  endtask

  task automatic m_fire(input int x, input int y, input int o, output bit ok);
    ok = 0;
    for (int i = 0; i < N; i++) begin
      if (!ml[i] && !ok) begin mx[i] = x; my[i] = y; mo[i] = o; ml[i] = 1; ok = 1; end
    end
  endtask

  // Step first, then decide what falling off the grid means.
  task automatic m_next(input int i, output int tx, output int ty, output bit off);
    tx = mx[i] + (mo[i] == 3 ? 1 : 0) - (mo[i] == 2 ? 1 : 0);
    ty = my[i] + (mo[i] == 1 ? 1 : 0) - (mo[i] == 0 ? 1 : 0);
    off = (tx < CMIN) || (tx > CMAX) || (ty < CMIN) || (ty > CMAX);
    if (tx < CMIN) tx = CMAX;
    if (tx > CMAX) tx = CMIN;
    if (ty < CMIN) ty = CMAX;
    if (ty > CMAX) ty = CMIN;
  endtask

  task automatic m_sweep(input bit av, input int ax, input int ay);
    int tx, ty;
    bit off;
    for (int i = 0; i < N; i++) begin
      ev[i] = 0;
      if (ml[i]) begin
        m_next(i, tx, ty, off);
`ifdef TIRO_WRAP_EN
        off = 0;
`endif
        if (off) begin
          ml[i] = 0; ev[i] = 1;
        end else begin
          mx[i] = tx; my[i] = ty;
          if (av && tx == ax && ty == ay) begin ml[i] = 0; ev[i] = 2; last_hit = i; end
        end
      end
    end
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < N; i++) begin
      db_idx = IW'(i);
      #1;
      chk({tag, "_loaded"}, 32'(db_loaded), 32'(ml[i]));
      chk({tag, "_x"}, 32'(db_x), 32'(mx[i]));
      chk({tag, "_y"}, 32'(db_y), 32'(my[i]));
      chk({tag, "_op"}, 32'(db_opcode), 32'(mo[i]));
    end
    chk({tag, "_ativos"}, 32'(tiros_ativos), 32'(m_count()));
  endtask

  task automatic do_fire(input int x, input int y, input int o);
    bit ok;
    @(negedge clock);
    nave_x = W'(x); nave_y = W'(y); nave_opcode = 2'(o); disparo = 1'b1;
    @(negedge clock);
    disparo = 1'b0;
    m_fire(x, y, o, ok);
    chk("fire_aceito", 32'(disparo_aceito), 32'(ok));
    chk("fire_recusado", 32'(disparo_recusado), 32'(!ok));
    chk("fire_ativos", 32'(tiros_ativos), 32'(m_count()));
  endtask

  task automatic do_sweep(input bit av, input int ax, input int ay,
                          input bit wf, input int fx, input int fy, input int fo, input bit poke);
    bit ok;
    @(negedge clock);
    aste_valido = av; aste_x = W'(ax); aste_y = W'(ay); atualiza = 1'b1;
    if (wf) begin nave_x = W'(fx); nave_y = W'(fy); nave_opcode = 2'(fo); disparo = 1'b1; end
    @(negedge clock);
    atualiza = 1'b0; disparo = 1'b0;
    if (wf) begin
      m_fire(fx, fy, fo, ok);
      chk("swf_aceito", 32'(disparo_aceito), 32'(ok));
    end
    m_sweep(av, ax, ay);
    chk("sw_ocupado0", 32'(ocupado), 32'd1);
    chk("sw_fim0", 32'(varredura_fim), 32'd0);
    for (int k = 0; k <= N; k++) begin
      if (poke && k == 3) begin disparo = 1'b1; atualiza = 1'b1; end
      @(negedge clock);
      disparo = 1'b0; atualiza = 1'b0;
      if (poke && k == 3) chk("busy_recusado", 32'(disparo_recusado), 32'd1);
      if (k < N) begin
        chk("sw_borda", 32'(borda), 32'(ev[k] == 1));
        chk("sw_colisao", 32'(colisao), 32'(ev[k] == 2));
        chk("sw_ocupado", 32'(ocupado), 32'd1);
        chk("sw_fim", 32'(varredura_fim), 32'd0);
      end else begin
        chk("sw_fim_pulse", 32'(varredura_fim), 32'd1);
        chk("sw_ocupado_drop", 32'(ocupado), 32'd0);
      end
    end
    chk("sw_colisao_idx", 32'(colisao_idx), 32'(last_hit));
    chk("sw_ativos", 32'(tiros_ativos), 32'(m_count()));
    if (poke) begin
      @(negedge clock);
      chk("busy_atualiza_ignored", 32'(ocupado), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int j, tx, ty;
    bit off, av;
    m_reset();
    reset = 1'b1;
    #12;
    reset = 1'b0;

    // Reset state
    chk("rst_ativos", 32'(tiros_ativos), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_colisao_idx", 32'(colisao_idx), 32'd0);
    check_bank("rst");

    // One shot right from (7,7), three sweeps
    do_fire(7, 7, 3);
    repeat (3) do_sweep(0, 0, 0, 0, 0, 0, 0, 0);
    db_idx = '0; #1;
    chk("move3_x", 32'(db_x), 32'd10);
    chk("move3_y", 32'(db_y), 32'd7);
    chk("move3_ativos", 32'(tiros_ativos), 32'd1);
    check_bank("move3");

    // Fill the bank and overflow
    do_reset();
    for (int i = 0; i < N; i++) do_fire($urandom_range(CMIN, CMAX), $urandom_range(CMIN, CMAX), $urandom_range(0, 3));
    do_fire(3, 3, 0);
    chk("full_ativos", 32'(tiros_ativos), 32'd16);
    check_bank("full");

    // Collision at bottom border, then same shot with asteroid absent
    do_reset();
    do_fire(7, 13, 1);
    do_sweep(1, 7, 14, 0, 0, 0, 0, 0);
    chk("hit_idx", 32'(colisao_idx), 32'd0);
    chk("hit_ativos", 32'(tiros_ativos), 32'd0);
    check_bank("hit");
    do_fire(7, 13, 1);
    do_sweep(0, 7, 14, 0, 0, 0, 0, 0);
    db_idx = '0; #1;
    chk("nohit_y", 32'(db_y), 32'd14);
    chk("nohit_loaded", 32'(db_loaded), 32'd1);

    // Right border
    do_reset();
    do_fire(14, 3, 3);
    do_sweep(0, 0, 0, 0, 0, 0, 0, 0);
    check_bank("border");

    // Fire and sweep on the same edge, shot leaves at left border
    do_reset();
    do_sweep(0, 0, 0, 1, 0, 5, 2, 0);
    check_bank("fire_sweep");

    // Asynchronous reset mid-sweep
    do_reset();
    for (int i = 0; i < 5; i++) do_fire(2 + i, 6, 1);
    @(negedge clock); atualiza = 1'b1;
    @(negedge clock); atualiza = 1'b0;
    repeat (8) @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    chk("midrst_ocupado", 32'(ocupado), 32'd0);
    chk("midrst_ativos", 32'(tiros_ativos), 32'd0);
    reset = 1'b0;
    m_reset();
    check_bank("midrst");

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0, 1: do_fire($urandom_range(CMIN, CMAX), $urandom_range(CMIN, CMAX), $urandom_range(0, 3));
        default: begin
          j = $urandom_range(0, N - 1);
          m_next(j, tx, ty, off);
          if ($urandom_range(0, 2) == 0) begin tx = $urandom_range(CMIN, CMAX); ty = $urandom_range(CMIN, CMAX); end
          av = ($urandom_range(0, 3) != 0);
          do_sweep(av, tx, ty, $urandom_range(0, 1) == 1, $urandom_range(CMIN, CMAX),
                   $urandom_range(CMIN, CMAX), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end
      endcase
      check_bank("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tiro_banco.md
Name: tiro_banco

Overview:
Parametrised multi-slot projectile engine that supersedes the single-path shot datapath. It holds N_TIROS shots with position, direction and loaded flag, fires new shots from the ship position into the first free slot, and advances every loaded shot one step per sweep. It also detects border exits and asteroid hits and frees slots autonomously through an internal FSM. It sits between the game control unit (fire/tick requests) and the asteroid/render logic.

Parameters:
N_TIROS, 16, number of shot slots (power of two, >=2)
COORD_W, 4, width of each x/y coordinate
COORD_MIN, 0, lowest valid coordinate on both axes
COORD_MAX, 14, highest valid coordinate on both axes

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
disparo  in  1  fire request pulse (one cycle)
atualiza  in  1  movement tick pulse; starts one sweep over all slots
nave_x  in  COORD_W  ship x, launch position
nave_y  in  COORD_W  ship y, launch position
nave_opcode  in  2  launch direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
aste_x  in  COORD_W  asteroid x
aste_y  in  COORD_W  asteroid y
aste_valido  in  1  asteroid present; collisions ignored when 0
db_idx  in  clog2(N_TIROS)  debug/render read slot index
ocupado  out  1  high while sweep in progress
disparo_aceito  out  1  one-cycle pulse, shot loaded
disparo_recusado  out  1  one-cycle pulse, request dropped
colisao  out  1  one-cycle pulse, shot hit asteroid
colisao_idx  out  clog2(N_TIROS)  slot of last hit, held until next hit
borda  out  1  one-cycle pulse, shot removed at border
varredura_fim  out  1  one-cycle pulse, sweep finished
tiros_ativos  out  clog2(N_TIROS+1)  count of loaded slots
db_x, db_y  out  COORD_W  position of slot db_idx (combinational)
db_opcode  out  2  direction of slot db_idx
db_loaded  out  1  loaded flag of slot db_idx

Behaviour:
- Reset (async, any state): FSM -> OCIOSO; all loaded flags, positions, opcodes, counters, colisao_idx and pulse outputs = 0.
- States: OCIOSO, VARRE, FIM.
- OCIOSO + disparo: a combinational priority encoder picks the lowest-index free slot. That slot gets x=nave_x, y=nave_y, opcode=nave_opcode and loaded=1 on the same edge. disparo_aceito pulses next cycle and tiros_ativos increments. If all slots are loaded, disparo_recusado pulses and nothing changes.
- OCIOSO + atualiza: slot index i=0 and FSM -> VARRE; ocupado=1 from the next cycle. If disparo and atualiza arrive together, the fire is performed first (same edge), and the new shot is moved in this sweep.
- VARRE: one slot per cycle, i = 0..N_TIROS-1.
  - Unloaded slot: no change.
  - Loaded slot whose move would leave [COORD_MIN, COORD_MAX] on its axis (up at y=COORD_MIN, down at y=COORD_MAX, left at x=COORD_MIN, right at x=COORD_MAX): loaded := 0, borda pulse, tiros_ativos decrements.
  - Otherwise the position steps by one on its axis. If aste_valido and the new (x,y) equals (aste_x,aste_y): loaded := 0, colisao pulse, colisao_idx := i, tiros_ativos decrements. The new position is still written.
  - After i = N_TIROS-1 the FSM goes to FIM. Sweep length is exactly N_TIROS cycles.
- FIM: varredura_fim pulses for one cycle, ocupado drops, FSM -> OCIOSO.
- disparo while ocupado: disparo_recusado pulses. atualiza while ocupado: ignored with no queueing.
- Arithmetic is width-safe; the border check precedes the step, so wrap-around never occurs without the macro.
- tiros_ativos never exceeds N_TIROS and never underflows; at most one +/-1 change per cycle.
- Pulse outputs are registered and high exactly one cycle.

Optional Feature:
TIRO_WRAP_EN defined: a shot at the border reappears at the opposite border on the same axis (COORD_MIN<->COORD_MAX) instead of being freed, and borda never pulses. The collision check is applied at the wrapped position.
Not defined: border removal as above.

Test Plan:
- Reset mid-sweep (i=7) -> all db_loaded=0, tiros_ativos=0, ocupado=0 next cycle.
- disparo with nave=(7,7), opcode 11, then atualiza x3 -> slot0 at (10,7), tiros_ativos=1; each sweep lasts 16 cycles then varredura_fim.
- Fire 16 shots, then a 17th -> 16 disparo_aceito, then disparo_recusado, tiros_ativos=16.
- Shot at (7,13) opcode 01, aste=(7,14) valid, atualiza -> colisao, colisao_idx=0, slot freed. Repeat with aste_valido=0 -> shot moves to (7,14), no pulse.
- Shot at (14,3) opcode 11, atualiza -> borda, slot freed. With TIRO_WRAP_EN -> shot at (0,3), no borda.
- disparo and atualiza same cycle with empty bank, nave=(0,5), opcode 10 -> shot loaded then immediately removed by borda within the same sweep.
